// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// default bit timing for 115200 baud on a 50 MHz clock, and character width.
package uart_pkg;

    // 50 MHz / 115200 baud, rounded to the nearest whole cycle.
    localparam int CLKS_PER_BIT_115200 = 434;

    // Data bits per character (8N1 framing).
    localparam int UART_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for asynchronous inputs.
// Ports:
//   i_clk - destination clock
//   i_rst - synchronous active-high reset; both flops load RST_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output, two cycles after a change on i_d
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizes the serial line, samples each bit
// at its midpoint and presents the received byte with a one-cycle strobe.
// Ports:
//   clk_50M     - system clock, rising edge
//   reset       - synchronous active-high reset
//   uart_rx     - asynchronous serial input, idle high
//   rx_msg      - last correctly framed byte, held until the next good frame
//   rx_complete - one-cycle pulse when rx_msg is updated
//   frame_error - one-cycle pulse when the stop bit was sampled low
//   rx_busy     - high whenever the receiver is not idle
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [UART_BITS-1:0] rx_msg,
    output logic                 rx_complete,
    output logic                 frame_error,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Start bit is checked half a bit in, which places every later
    // sample at the centre of its bit cell.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic                 w_rx_s;

    rx_state_e            r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [UART_BITS-1:0] r_shift;
    logic [UART_BITS-1:0] r_msg;
    logic                 r_complete;
    logic                 r_ferr;

    rx_state_e            w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic [UART_BITS-1:0] w_shift_nxt;
    logic [UART_BITS-1:0] w_msg_nxt;
    logic                 w_complete_nxt;
    logic                 w_ferr_nxt;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (clk_50M),
        .i_rst (reset),
        .i_d   (uart_rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_msg      <= '0;
            r_complete <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_msg      <= w_msg_nxt;
            r_complete <= w_complete_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CW'(1);
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_msg_nxt      = r_msg;
        w_complete_nxt = 1'b0;
        w_ferr_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = START;
                end
            end

            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        // Line already back high: a glitch, not a start bit.
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
            end

            DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[UART_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end

            STOP: begin
                if (r_cnt == FULL_M1) begin
                    // Leave at mid stop bit so a following start edge
                    // with no idle gap is still caught.
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        w_msg_nxt      = r_shift;
                        w_complete_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_msg      = r_msg;
    assign rx_complete = r_complete;
    assign frame_error = r_ferr;
    assign rx_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: serial frames are driven at chosen
// baud rates and a monitor checks every strobe against queued expectations.
module tb_uart_rx_byte;

    localparam int CPB = 434;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       frame_error;
    logic       rx_busy;

    int         pass_cnt = 0;
    int         tot_cnt  = 0;
    int         cyc      = 0;
    exp_t       exp_q[$];
    int         ts_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_msg      (rx_msg),
        .rx_complete (rx_complete),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc = cyc + 1;

    task automatic chk(input string nm, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
        tot_cnt = tot_cnt + 1;
        if (ok) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk_50M) begin
        exp_t e;
        if (reset) begin
            last_good = 8'h00;
        end else if (rx_complete || frame_error) begin
            chk("strobe_exclusive", !(rx_complete && frame_error),
                32'(rx_complete & frame_error), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1'b0,
                    {30'd0, rx_complete, frame_error}, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.ferr) begin
                    chk("kind_ferr", frame_error && !rx_complete,
                        {30'd0, rx_complete, frame_error}, 1);
                    chk("msg_held", rx_msg == last_good, rx_msg, last_good);
                end else begin
                    chk("kind_byte", rx_complete && !frame_error,
                        {30'd0, rx_complete, frame_error}, 2);
                    chk("byte", rx_msg == e.data, rx_msg, e.data);
                    last_good = e.data;
                    ts_q.push_back(cyc);
                end
            end
        end
    end

    // Drive one 8N1 frame with per cycles per bit. abort_bit >= 0 pulses
    // reset in the middle of that data bit and abandons the frame.
    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input int per, input int abort_bit = -1);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        if (abort_bit < 0) exp_q.push_back('{ferr: !stop_ok, data: b});
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            for (int c = 0; c < per; c++) begin
                @(negedge clk_50M);
                if (abort_bit >= 0 && i == abort_bit + 1 && c == per / 2) begin
                    reset = 1'b1;
                    @(negedge clk_50M);
                    reset   = 1'b0;
                    uart_rx = 1'b1;
                    return;
                end
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic wait_drain(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk_50M);
            if (exp_q.size() == 0) done = 1'b1;
        end
        chk(nm, done, exp_q.size(), 0);
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per;
        int gap;
        bit sok;
        logic [7:0] b;

        repeat (5) @(negedge clk_50M);
        reset = 1'b0;
        @(negedge clk_50M);
        chk("rst_msg", rx_msg == 8'h00, rx_msg, 0);
        chk("rst_complete", rx_complete == 1'b0, rx_complete, 0);
        chk("rst_ferr", frame_error == 1'b0, frame_error, 0);
        chk("rst_busy", rx_busy == 1'b0, rx_busy, 0);
        idle(20);

        // Single '#' character.
        send(8'h23, 1'b1, CPB);
        wait_drain("drain_single");
        idle(2 * CPB);

        // Three frames back to back with no idle bits.
        ts_q.delete();
        send(8'h49, 1'b1, CPB);
        send(8'h46, 1'b1, CPB);
        send(8'h4D, 1'b1, CPB);
        wait_drain("drain_b2b");
        chk("b2b_count", ts_q.size() == 3, ts_q.size(), 3);
        if (ts_q.size() == 3) begin
            chk("b2b_gap1", ts_q[1] - ts_q[0] == 10 * CPB,
                ts_q[1] - ts_q[0], 10 * CPB);
            chk("b2b_gap2", ts_q[2] - ts_q[1] == 10 * CPB,
                ts_q[2] - ts_q[1], 10 * CPB);
        end
        idle(2 * CPB);

        // 100-cycle low glitch on an idle line.
        uart_rx = 1'b0;
        repeat (50) @(negedge clk_50M);
        chk("glitch_busy_hi", rx_busy == 1'b1, rx_busy, 1);
        repeat (50) @(negedge clk_50M);
        idle(300);
        chk("glitch_busy_lo", rx_busy == 1'b0, rx_busy, 0);
        idle(CPB);

        // Bad stop bit: frame_error, rx_msg keeps 8'h4D.
        send(8'h45, 1'b0, CPB);
        wait_drain("drain_ferr");
        chk("ferr_msg_kept", rx_msg == 8'h4D, rx_msg, 8'h4D);
        idle(2 * CPB);

        // Reset mid data bit 4 of 8'h52, then a clean 8'h43.
        send(8'h52, 1'b1, CPB, 4);
        idle(2 * CPB);
        chk("abort_msg_cleared", rx_msg == 8'h00, rx_msg, 0);
        chk("abort_idle", rx_busy == 1'b0, rx_busy, 0);
        send(8'h43, 1'b1, CPB);
        wait_drain("drain_after_abort");
        idle(2 * CPB);

        // Baud tolerance: +3% and -3% bit periods.
        send(8'h55, 1'b1, (CPB * 103) / 100);
        wait_drain("drain_slow");
        idle(2 * CPB);
        send(8'h55, 1'b1, (CPB * 97) / 100);
        wait_drain("drain_fast");
        idle(2 * CPB);

        // Random bytes, stop bits and baud within +/-3%.
        for (int k = 0; k < 4; k++) begin
            b   = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 3) != 0);
            per = CPB - 13 + int'($urandom_range(0, 26));
            gap = int'($urandom_range(0, 50));
            send(b, sok, per);
            idle(gap);
        end
        wait_drain("drain_random");
        idle(2 * CPB);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-byte receiver for the ground-station UART link. Oversamples the asynchronous `uart_rx` line on `clk_50M` and deframes 8N1 characters. Delivers each byte on `rx_msg` with a one-cycle `rx_complete` strobe. Sits directly upstream of the message decoder, which collects bytes up to the `#` terminator and raises the fault and pick-block flags.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud); legal range ≥ 8.

Ports:
- `clk_50M` in, 1 bit: single system clock; all logic on the rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `uart_rx` in, 1 bit: asynchronous serial line; idle high.
- `rx_msg` out, 8 bits: last correctly framed byte; held until the next good frame.
- `rx_complete` out, 1 bit: one-cycle pulse when `rx_msg` is updated.
- `frame_error` out, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `rx_busy` out, 1 bit: high in every state except IDLE.

## Operation
- `uart_rx` passes through a 2-FF synchronizer, giving `rx_s`. No other logic reads `uart_rx` directly.
- `HALF` = `CLKS_PER_BIT`/2, integer division.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. It resets to 0 on every state change and every bit sample.
- The data shift register is 8 bits, LSB received first (shift right, new bit into [7]).

FSM:
- **IDLE**: wait for `rx_s`==0, then enter START with count 0.
- **START**: count to `HALF`-1, then sample `rx_s`.
  - 1 → glitch: return to IDLE, no output.
  - 0 → DATA, bit index 0.
- **DATA**: count to `CLKS_PER_BIT`-1, then sample and shift. After bit index 7 → STOP.
- **STOP**: count to `CLKS_PER_BIT`-1, then sample.
  - 1 → load `rx_msg` from the shift register and pulse `rx_complete`.
  - 0 → pulse `frame_error`; `rx_msg` unchanged.
  - Either case → IDLE.
- Return to IDLE happens at the stop-bit midpoint. A start edge from then on is accepted, so back-to-back frames with no idle gap are received.
- A break (line held low) gives one `frame_error`. IDLE then re-arms only after the line has been seen low; the break's continued low is treated as a new start and is handled by the same rules.
- Reset values: `rx_msg`=8'h00, `rx_complete`=0, `frame_error`=0, `rx_busy`=0, FSM=IDLE, counters 0, both synchronizer flops 1.
- Reset mid-frame aborts the frame. No strobe is produced, and the partial byte is discarded.
- `rx_complete` and `frame_error` are never high in the same cycle.

## Timing
- Synchronizer latency: 2 cycles from a `uart_rx` edge to `rx_s`.
- Let t0 be the first cycle `rx_s`==0 in IDLE. The start is sampled at t0+`HALF`. Data bit k (0..7) is sampled at t0+`HALF`+(k+1)·`CLKS_PER_BIT`. The stop bit is sampled at t0+`HALF`+9·`CLKS_PER_BIT`.
- `rx_complete`/`frame_error` are registered: high in the cycle after the stop sample, for exactly 1 cycle. `rx_msg` is valid in that same cycle.
- No backpressure. The consumer must take the byte within one frame time (10·`CLKS_PER_BIT` cycles).
- Tolerance: frames within ±3% of nominal baud must be received correctly.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - `CLKS_PER_BIT_115200` = 434.
  - `UART_BITS` = 8.
- Sub-module `sync_2ff`: a generic 1-bit two-flop synchronizer with reset value parameter `RST_VAL`=1. It is reused by other asynchronous inputs (keys).

## Test plan
- Single frame 8'h23 (`#`) at nominal baud → one `rx_complete` pulse, `rx_msg`=8'h23, `frame_error` never high.
- Back-to-back 8'h49, 8'h46, 8'h4D with zero idle bits → three `rx_complete` pulses exactly 10·434 cycles apart, with bytes in order.
- Low glitch of 100 cycles on an idle line → `rx_busy` high then low, and no `rx_complete` or `frame_error`.
- Frame 8'h45 with stop bit forced 0 → one `frame_error` pulse, no `rx_complete`, `rx_msg` keeps its previous value.
- `reset` asserted for 1 cycle during data bit 4 of 8'h52, then a clean 8'h43 → no strobe for the aborted frame, then `rx_msg`=8'h43 with one `rx_complete`.
- 8'h55 sent at +3% and −3% baud → received as 8'h55 in both cases.
